// File: rtl/spi_mst_seq.sv
// Command sequencer in front of spi_master: packs up to 16 command bytes, launches one
// transfer, waits for it to complete, then streams the received bytes back.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | accept command bytes into the transmit buffer
// S_START | start asserted, waiting for master busy (start timeout runs)
// S_WAIT  | transfer in flight, waiting for master busy to fall
// S_DRAIN | present received bytes on the response stream
module spi_mst_seq #(
    parameter int unsigned START_TO = 64
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         cmd_valid,
    input  logic [7:0]   cmd_data,
    input  logic         cmd_last,
    output logic         cmd_ready,
    output logic         rsp_valid,
    output logic [7:0]   rsp_data,
    output logic         rsp_last,
    input  logic         rsp_ready,
    output logic         seq_busy,
    output logic         seq_err,
    output logic [127:0] mst_wfifo,
    output logic [7:0]   mst_ctrl,
    input  logic [127:0] mst_rfifo,
    input  logic [7:0]   mst_status
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [7:0] TMR_LOAD = 8'(START_TO - 1);

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [3:0]   idx_q, idx_d;
    logic [3:0]   len_q, len_d;
    logic [7:0]   tmr_q, tmr_d;
    logic [127:0] rbuf_q, rbuf_d;
    logic [127:0] wfifo_q, wfifo_d;
    logic [7:0]   ctrl_q, ctrl_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic [7:0]   rsp_data_q, rsp_data_d;
    logic         rsp_last_q, rsp_last_d;
    logic         busy_q, busy_d;
    logic         err_q, err_d;

    logic         cmd_acc;
    logic         pkt_end;
    logic         rsp_acc;
    logic         mst_busy;
    logic [3:0]   idx_nxt;
    logic         unused_status;

    function automatic logic [7:0] byte_at(input logic [127:0] v, input logic [3:0] i);
        logic [127:0] s;
        s = v << {i, 3'b000};
        return s[127:120];
    endfunction

    assign cmd_ready     = (state_q == S_IDLE);
    assign cmd_acc       = cmd_valid & cmd_ready;
    assign pkt_end       = cmd_last | (cnt_q == 4'hF);
    assign rsp_acc       = rsp_valid_q & rsp_ready;
    assign mst_busy      = mst_status[7];
    assign unused_status = ^mst_status[6:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_acc && pkt_end) state_d = S_START;
            end
            S_START: begin
                if (mst_busy)           state_d = S_WAIT;
                else if (tmr_q == 8'd0) state_d = S_IDLE;
            end
            S_WAIT: begin
                if (!mst_busy) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (rsp_acc && rsp_last_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        len_d       = len_q;
        tmr_d       = tmr_q;
        rbuf_d      = rbuf_q;
        wfifo_d     = wfifo_q;
        ctrl_d      = ctrl_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_last_d  = rsp_last_q;
        err_d       = 1'b0;
        idx_nxt     = idx_q + 4'd1;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_acc) begin
                    // slots are zero until written, so OR-ing the shifted byte places it
                    wfifo_d = wfifo_q | ({cmd_data, 120'd0} >> {cnt_q, 3'b000});
                    cnt_d   = cnt_q + 4'd1;
                    if (pkt_end) begin
                        len_d  = cnt_q;
                        ctrl_d = {1'b1, 3'b000, cnt_q};
                        tmr_d  = TMR_LOAD;
                    end
                end
            end
            S_START: begin
                if (mst_busy) begin
                    ctrl_d = 8'd0;
                end else if (tmr_q == 8'd0) begin
                    ctrl_d  = 8'd0;
                    err_d   = 1'b1;
                    cnt_d   = 4'd0;
                    wfifo_d = '0;
                end else begin
                    tmr_d = tmr_q - 8'd1;
                end
            end
            S_WAIT: begin
                if (!mst_busy) begin
                    rbuf_d      = mst_rfifo;
                    idx_d       = 4'd0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = mst_rfifo[127:120];
                    rsp_last_d  = (len_q == 4'd0);
                end
            end
            S_DRAIN: begin
                if (rsp_acc) begin
                    if (rsp_last_q) begin
                        rsp_valid_d = 1'b0;
                        rsp_data_d  = 8'd0;
                        rsp_last_d  = 1'b0;
                        idx_d       = 4'd0;
                        cnt_d       = 4'd0;
                        wfifo_d     = '0;
                    end else begin
                        idx_d      = idx_nxt;
                        rsp_data_d = byte_at(rbuf_q, idx_nxt);
                        rsp_last_d = (idx_nxt == len_q);
                    end
                end
            end
            default: ;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q       <= 4'd0;
            idx_q       <= 4'd0;
            len_q       <= 4'd0;
            tmr_q       <= 8'd0;
            rbuf_q      <= '0;
            wfifo_q     <= '0;
            ctrl_q      <= 8'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'd0;
            rsp_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            tmr_q       <= tmr_d;
            rbuf_q      <= rbuf_d;
            wfifo_q     <= wfifo_d;
            ctrl_q      <= ctrl_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign mst_wfifo = wfifo_q;
    assign mst_ctrl  = ctrl_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_last  = rsp_last_q;
    assign seq_busy  = busy_q;
    assign seq_err   = err_q;

endmodule

// File: tb/tb_spi_mst_seq.sv
// Bench for spi_mst_seq: behavioural spi_master stand-in, packet-level reference model,
// table-driven packet vectors, randomized streams and hand-written corner sequences.
module tb_spi_mst_seq;

    logic         clk;
    logic         rstn;
    logic         cmd_valid;
    logic [7:0]   cmd_data;
    logic         cmd_last;
    logic         cmd_ready;
    logic         rsp_valid;
    logic [7:0]   rsp_data;
    logic         rsp_last;
    logic         rsp_ready;
    logic         seq_busy;
    logic         seq_err;
    logic [127:0] mst_wfifo;
    logic [7:0]   mst_ctrl;
    logic [127:0] mst_rfifo;
    logic [7:0]   mst_status;

    spi_mst_seq #(.START_TO(64)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cmd_valid  (cmd_valid),
        .cmd_data   (cmd_data),
        .cmd_last   (cmd_last),
        .cmd_ready  (cmd_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_last   (rsp_last),
        .rsp_ready  (rsp_ready),
        .seq_busy   (seq_busy),
        .seq_err    (seq_err),
        .mst_wfifo  (mst_wfifo),
        .mst_ctrl   (mst_ctrl),
        .mst_rfifo  (mst_rfifo),
        .mst_status (mst_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] w;
        logic [3:0]   len;
    } xfer_t;

    typedef struct {
        int nbytes;
        int rdy;
        int sdelay;
        int sbusy;
        int exp_xfers;
        int exp_lasts;
    } vec_t;

    int checks = 0;
    int errors = 0;

    xfer_t      exp_xfer[$];
    logic [8:0] exp_rsp[$];
    logic [7:0] pkt[$];
    int         formed = 0;
    int         xfer_cnt = 0;
    int         n_last = 0;

    int           slv_en = 1;
    int           slv_delay = 1;
    int           slv_busy = 2;
    logic         slv_fixed_en = 1'b0;
    logic [127:0] slv_fixed = '0;
    int           sl_phase = 0;
    int           sl_cnt = 0;

    int   rdy_mode = 1;
    logic stall_prev = 1'b0;
    logic [7:0] prev_d = 8'd0;
    logic prev_l = 1'b0;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: group accepted bytes into packets of at most 16, each closed by last or size 16.
    task automatic model_push(input logic [7:0] d, input logic l);
        xfer_t x;
        logic [7:0] rb;
        pkt.push_back(d);
        if (l || pkt.size() == 16) begin
            x.w = '0;
            for (int k = 0; k < pkt.size(); k++) x.w[127 - 8*k -: 8] = pkt[k];
            x.len = 4'(pkt.size() - 1);
            exp_xfer.push_back(x);
            for (int k = 0; k < pkt.size(); k++) begin
                rb = slv_fixed_en ? slv_fixed[127 - 8*k -: 8] : (pkt[k] ^ 8'h5A);
                exp_rsp.push_back({rb, (k == pkt.size() - 1) ? 1'b1 : 1'b0});
            end
            formed++;
            pkt.delete();
        end
    endtask

    task automatic model_clear();
        exp_xfer.delete();
        exp_rsp.delete();
        pkt.delete();
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int t;
        t = 0;
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_last  = l;
        @(negedge clk);
        while (!cmd_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (cmd_ready) model_push(d, l);
        else chk("cmd_accept_timeout", {127'd0, cmd_ready}, 128'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_data  = 8'd0;
        cmd_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while ((exp_rsp.size() != 0 || exp_xfer.size() != 0 || !cmd_ready) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_done", 128'(exp_rsp.size()), 128'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_status_high();
        int t;
        t = 0;
        @(negedge clk);
        while (!mst_status[7] && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("status_seen", {127'd0, mst_status[7]}, 128'd1);
    endtask

    // spi_master stand-in: busy after slv_delay, returns data when busy falls.
    always @(negedge clk) begin
        xfer_t x;
        if (!rstn) begin
            sl_phase   = 0;
            sl_cnt     = 0;
            mst_status = 8'h00;
        end else begin
            case (sl_phase)
                0: if (mst_ctrl[7] && slv_en != 0) begin
                    xfer_cnt++;
                    if (exp_xfer.size() == 0) begin
                        chk("xfer_expected", 128'(exp_xfer.size()), 128'd1);
                    end else begin
                        x = exp_xfer.pop_front();
                        chk("xfer_wfifo", mst_wfifo, x.w);
                        chk("xfer_len", {124'd0, mst_ctrl[3:0]}, {124'd0, x.len});
                        chk("xfer_ctrl_rsvd", {125'd0, mst_ctrl[6:4]}, 128'd0);
                    end
                    sl_cnt   = slv_delay;
                    sl_phase = 1;
                end
                1: if (sl_cnt == 0) begin
                    mst_status = 8'h80;
                    mst_rfifo  = slv_fixed_en ? slv_fixed : (mst_wfifo ^ {16{8'h5A}});
                    sl_cnt     = slv_busy;
                    sl_phase   = 2;
                end else begin
                    sl_cnt--;
                end
                default: if (sl_cnt == 0) begin
                    mst_status = 8'h00;
                    sl_phase   = 0;
                end else begin
                    sl_cnt--;
                end
            endcase
        end
    end

    // Response monitor: ordering, content, hold-while-stalled, busy/ready consistency.
    always @(negedge clk) begin
        logic [8:0] e;
        if (!rstn) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("rsp_hold_valid", {127'd0, rsp_valid}, 128'd1);
                chk("rsp_hold_data", {120'd0, rsp_data}, {120'd0, prev_d});
                chk("rsp_hold_last", {127'd0, rsp_last}, {127'd0, prev_l});
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_rsp.size() == 0) begin
                    chk("rsp_unexpected", 128'(exp_rsp.size()), 128'd1);
                end else begin
                    e = exp_rsp.pop_front();
                    chk("rsp_data", {120'd0, rsp_data}, {120'd0, e[8:1]});
                    chk("rsp_last", {127'd0, rsp_last}, {127'd0, e[0]});
                end
                if (rsp_last) n_last++;
            end
            if (seq_busy === cmd_ready) chk("busy_vs_ready", {127'd0, seq_busy}, {127'd0, ~cmd_ready});
            stall_prev = rsp_valid && !rsp_ready;
            prev_d     = rsp_data;
            prev_l     = rsp_last;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       rsp_ready = 1'b0;
                1:       rsp_ready = 1'b1;
                default: rsp_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        int n;
        int err_cnt;
        int err_at;
        logic l;

        vecs[0] = '{1,  1, 0, 1, 1, 1};
        vecs[1] = '{5,  2, 3, 4, 1, 1};
        vecs[2] = '{16, 2, 1, 2, 1, 1};
        vecs[3] = '{17, 1, 2, 3, 2, 2};
        vecs[4] = '{32, 2, 0, 1, 2, 2};
        vecs[5] = '{33, 1, 5, 1, 3, 3};

        rstn       = 1'b0;
        cmd_valid  = 1'b0;
        cmd_data   = 8'd0;
        cmd_last   = 1'b0;
        rsp_ready  = 1'b1;
        mst_rfifo  = '0;
        mst_status = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_wfifo", mst_wfifo, 128'd0);
        chk("rst_ctrl", {120'd0, mst_ctrl}, 128'd0);
        chk("rst_cmd_ready", {127'd0, cmd_ready}, 128'd1);
        chk("rst_rsp", {118'd0, rsp_valid, rsp_data, rsp_last}, 128'd0);
        chk("rst_busy_err", {126'd0, seq_busy, seq_err}, 128'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // single byte, fixed loopback 0x3C
        slv_fixed_en = 1'b1;
        slv_fixed    = {8'h3C, 120'd0};
        slv_delay    = 2;
        n_last       = 0;
        send_byte(8'hA5, 1'b1);
        chk("single_ctrl_start", {120'd0, mst_ctrl}, {120'd0, 8'h80});
        chk("single_wfifo", mst_wfifo, {8'hA5, 120'd0});
        wait_status_high();
        @(posedge clk);
        #1;
        chk("single_ctrl_clear", {120'd0, mst_ctrl}, 128'd0);
        wait_idle();
        chk("single_lasts", 128'(n_last), 128'd1);

        // full 16 bytes
        slv_fixed = {4{32'hBABE_FACE}};
        n_last    = 0;
        for (int i = 0; i < 16; i++) send_byte(8'(i), (i == 15) ? 1'b1 : 1'b0);
        chk("full_ctrl", {120'd0, mst_ctrl}, {120'd0, 8'h8F});
        wait_idle();
        chk("full_lasts", 128'(n_last), 128'd1);
        slv_fixed_en = 1'b0;

        // split packet: 18 bytes, ready held low until first drain completes
        n_last = 0;
        for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b0);
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("split_first_last", 128'(n_last), 128'd1);
        chk("split_first_drained", 128'(exp_rsp.size()), 128'd0);
        @(posedge clk);
        #1;
        send_byte(8'($urandom), 1'b0);
        send_byte(8'($urandom), 1'b1);
        chk("split_second_ctrl", {120'd0, mst_ctrl}, {120'd0, 8'h81});
        wait_idle();
        chk("split_lasts", 128'(n_last), 128'd2);

        // table-driven packet vectors
        foreach (vecs[v]) begin
            rdy_mode  = vecs[v].rdy;
            slv_delay = vecs[v].sdelay;
            slv_busy  = vecs[v].sbusy;
            xfer_cnt  = 0;
            n_last    = 0;
            for (int i = 0; i < vecs[v].nbytes; i++)
                send_byte(8'($urandom), (i == vecs[v].nbytes - 1) ? 1'b1 : 1'b0);
            wait_idle();
            chk("vec_xfers", 128'(xfer_cnt), 128'(vecs[v].exp_xfers));
            chk("vec_lasts", 128'(n_last), 128'(vecs[v].exp_lasts));
        end

        // back-pressure: stall 20 cycles, then random ready
        rdy_mode = 0;
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), (i == 7) ? 1'b1 : 1'b0);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        chk("bp_nothing_taken", 128'(exp_rsp.size()), 128'd8);
        rdy_mode = 2;
        wait_idle();

        // randomized streams with random packet boundaries
        for (int it = 0; it < 12; it++) begin
            rdy_mode  = $urandom_range(1, 2);
            slv_delay = $urandom_range(0, 6);
            slv_busy  = $urandom_range(1, 8);
            xfer_cnt  = 0;
            n_last    = 0;
            formed    = 0;
            n = $urandom_range(1, 40);
            for (int j = 0; j < n; j++) begin
                l = (j == n - 1) || ($urandom_range(0, 5) == 0);
                send_byte(8'($urandom), l);
            end
            wait_idle();
            chk("rand_xfers", 128'(xfer_cnt), 128'(formed));
            chk("rand_lasts", 128'(n_last), 128'(formed));
        end
        rdy_mode = 1;

        // start timeout: master never goes busy
        slv_en = 0;
        send_byte(8'h77, 1'b1);
        err_cnt = 0;
        err_at  = 0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (seq_err) begin
                err_cnt++;
                err_at = i;
            end
        end
        chk("to_err_count", 128'(err_cnt), 128'd1);
        chk("to_err_cycle", 128'(err_at), 128'd65);
        chk("to_idle", {127'd0, cmd_ready}, 128'd1);
        chk("to_wfifo", mst_wfifo, 128'd0);
        chk("to_no_rsp", {127'd0, rsp_valid}, 128'd0);
        model_clear();
        slv_en = 1;
        @(posedge clk);
        #1;

        // reset in the middle of WAIT
        slv_delay = 1;
        slv_busy  = 40;
        send_byte(8'h11, 1'b1);
        wait_status_high();
        repeat (3) @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_wfifo", mst_wfifo, 128'd0);
        chk("mid_rst_ctrl", {120'd0, mst_ctrl}, 128'd0);
        chk("mid_rst_rsp", {118'd0, rsp_valid, rsp_data, rsp_last}, 128'd0);
        chk("mid_rst_busy_err", {126'd0, seq_busy, seq_err}, 128'd0);
        chk("mid_rst_ready", {127'd0, cmd_ready}, 128'd1);
        model_clear();
        @(negedge clk);
        @(posedge clk);
        #1;
        rstn     = 1'b1;
        slv_busy = 2;
        n_last   = 0;
        @(posedge clk);
        #1;
        send_byte(8'h42, 1'b1);
        wait_idle();
        chk("post_rst_lasts", 128'(n_last), 128'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
